// File: rtl/spi_fsm.sv
// -----------------------------------------------------------------------------
// spi_fsm -- SPI peripheral transaction controller.
//
// Sequences one SPI transaction per chip-select assertion: a WIDTH-bit address
// phase (bit 0 of the shifted word selects read=1 / write=0), then either a
// read phase (parallel-load the shift register, drive MISO for WIDTH falling
// edges) or a write phase (receive WIDTH bits, then strobe the data memory).
// Chip select deasserting aborts from any state. All outputs are registered.
//
// Optional feature: define SPI_FSM_TIMEOUT_EN to add a watchdog that aborts a
// stalled transaction into DONE after TIMEOUT_CYCLES clk cycles without SCLK
// activity, pulsing timeoutErr. Without it timeoutErr is tied to 0.
//
// Ports:
//   clk              system clock, rising-edge active
//   rst_n            asynchronous active-low reset
//   csConditioned    conditioned chip select, active low
//   sclkRise         1-clk pulse per conditioned SCLK rising edge
//   sclkFall         1-clk pulse per conditioned SCLK falling edge
//   shiftRegOut      shift register parallel output (bit 0 = R/W after address)
//   addrLatchEnable  1-cycle address latch load strobe
//   dmWriteEnable    1-cycle data memory write strobe
//   srParallelLoad   1-cycle shift register parallel load strobe
//   misoBufferEnable MISO tri-state enable during the read data phase
//   busy             high whenever not IDLE
//   timeoutErr       1-cycle pulse on watchdog expiry
// -----------------------------------------------------------------------------
module spi_fsm #(
   parameter int WIDTH          = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             csConditioned,
   input  logic             sclkRise,
   input  logic             sclkFall,
   input  logic [WIDTH-1:0] shiftRegOut,
   output logic             addrLatchEnable,
   output logic             dmWriteEnable,
   output logic             srParallelLoad,
   output logic             misoBufferEnable,
   output logic             busy,
   output logic             timeoutErr
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   typedef enum logic [2:0] {
      IDLE, GET_ADDR, ADDR_LATCH, READ_LOAD,
      READ_SHIFT, WRITE_RX, WRITE_COMMIT, DONE
   } state_t;

   state_t           state, stateNext;
   logic [CNT_W-1:0] edgeCnt, edgeCntNext;
   logic             countPulse;   // SCLK edge that the current state counts
   logic             lastEdge;     // this pulse completes a WIDTH-bit phase
   logic             wdogExpire;

   // Only bit 0 of the shifted word matters to the controller.
   logic unusedSro;
   assign unusedSro = ^shiftRegOut[WIDTH-1:1];

   always_comb begin
      stateNext   = state;
      edgeCntNext = edgeCnt;
      countPulse  = 1'b0;
      case (state)
         GET_ADDR, WRITE_RX: countPulse = sclkRise;
         READ_SHIFT:         countPulse = sclkFall;
         default:            countPulse = 1'b0;
      endcase
      // Saturating count; phases end on reaching WIDTH so it never wraps.
      if (countPulse && (edgeCnt != CNT_FULL)) edgeCntNext = edgeCnt + 1'b1;
      lastEdge = countPulse && (edgeCnt == CNT_LAST);

      case (state)
         IDLE: begin
            edgeCntNext = '0;
            stateNext   = GET_ADDR;   // cs check below keeps us idle
         end
         GET_ADDR:     if (lastEdge) stateNext = ADDR_LATCH;
         ADDR_LATCH: begin
            edgeCntNext = '0;
            stateNext   = shiftRegOut[0] ? READ_LOAD : WRITE_RX;
         end
         READ_LOAD:    stateNext = READ_SHIFT;
         READ_SHIFT:   if (lastEdge) stateNext = DONE;
         WRITE_RX:     if (lastEdge) stateNext = WRITE_COMMIT;
         WRITE_COMMIT: stateNext = DONE;
         DONE:         stateNext = DONE;
         default:      stateNext = IDLE;
      endcase

      if (wdogExpire) stateNext = DONE;

      // Chip select release wins over everything, including a same-cycle
      // final SCLK edge, so no strobe can follow it.
      if (csConditioned) begin
         stateNext   = IDLE;
         edgeCntNext = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         edgeCnt          <= '0;
         addrLatchEnable  <= 1'b0;
         dmWriteEnable    <= 1'b0;
         srParallelLoad   <= 1'b0;
         misoBufferEnable <= 1'b0;
         busy             <= 1'b0;
      end else begin
         state            <= stateNext;
         edgeCnt          <= edgeCntNext;
         // Outputs are decoded from the next state so they appear in the
         // same cycle the state is occupied, straight from flops.
         addrLatchEnable  <= (stateNext == ADDR_LATCH);
         dmWriteEnable    <= (stateNext == WRITE_COMMIT);
         srParallelLoad   <= (stateNext == READ_LOAD);
         misoBufferEnable <= (stateNext == READ_SHIFT);
         busy             <= (stateNext != IDLE);
      end
   end

`ifdef SPI_FSM_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wdog, wdogNext;

   // Counts stalled cycles in the states that wait on SCLK; any counted
   // edge restarts it, and every other state holds it at zero so each
   // waiting state starts with a fresh budget.
   always_comb begin
      wdogNext   = '0;
      wdogExpire = 1'b0;
      if ((state == GET_ADDR || state == READ_SHIFT || state == WRITE_RX)
          && !countPulse) begin
         if (wdog == WD_LAST) wdogExpire = 1'b1;
         else                 wdogNext   = wdog + 1'b1;
      end
      if (csConditioned) wdogNext = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog       <= '0;
         timeoutErr <= 1'b0;
      end else begin
         wdog       <= wdogNext;
         timeoutErr <= wdogExpire && !csConditioned;
      end
   end
`else
   localparam int unusedTimeout = TIMEOUT_CYCLES;
   assign wdogExpire = 1'b0;
   assign timeoutErr = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_fsm -- self-checking bench for spi_fsm (WIDTH=8, TIMEOUT_CYCLES=16).
// A transaction-level model tracks edge timestamps of each phase and is
// compared against the DUT on every falling clk edge; directed tests add
// hand-computed literal checks at the key cycles.
// -----------------------------------------------------------------------------
module tb_spi_fsm;
   localparam int W = 8;
   localparam int T = 16;
`ifdef SPI_FSM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         csConditioned = 1'b1;
   logic         sclkRise = 1'b0;
   logic         sclkFall = 1'b0;
   logic [W-1:0] shiftRegOut = '0;
   logic         addrLatchEnable, dmWriteEnable, srParallelLoad;
   logic         misoBufferEnable, busy, timeoutErr;

   int tests = 0;
   int fails = 0;

   spi_fsm #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .csConditioned(csConditioned),
      .sclkRise(sclkRise), .sclkFall(sclkFall), .shiftRegOut(shiftRegOut),
      .addrLatchEnable(addrLatchEnable), .dmWriteEnable(dmWriteEnable),
      .srParallelLoad(srParallelLoad), .misoBufferEnable(misoBufferEnable),
      .busy(busy), .timeoutErr(timeoutErr));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // Phases are located by the clk edge index at which they complete:
   // addrE = edge of the W-th address rise; read/write direction is taken
   // one edge later; data phase waits start one (write) or two (read)
   // edges after addrE. lastAct is the edge that last restarted the
   // inactivity budget.
   int e = 0, rises = 0, addrE = -1, lastAct = 0;
   bit active = 0, finished = 0, isRead = 0;
   bit eAle = 0, eSpl = 0, eDwe = 0, eMiso = 0, eBusy = 0, eTo = 0;

   function automatic bit stalled(input int edgeNow, input int since);
      return TO_EN && (edgeNow - since >= T);
   endfunction

   always @(posedge clk) begin
      e++;
      eAle = 0; eSpl = 0; eDwe = 0; eTo = 0;
      if (!rst_n || csConditioned) begin
         active = 0; eMiso = 0; eBusy = 0;
      end else if (!active) begin
         active = 1; eBusy = 1; rises = 0; addrE = -1; finished = 0;
         isRead = 0; lastAct = e;
      end else if (!finished) begin
         if (addrE < 0) begin
            if (sclkRise) begin
               rises++; lastAct = e;
               if (rises == W) begin addrE = e; eAle = 1; end
            end else if (stalled(e, lastAct)) begin
               eTo = 1; finished = 1;
            end
         end else if (e == addrE + 1) begin
            isRead = shiftRegOut[0]; rises = 0; lastAct = e;
            eSpl = isRead;
         end else if (!isRead) begin
            if (sclkRise) begin
               rises++; lastAct = e;
               if (rises == W) begin eDwe = 1; finished = 1; end
            end else if (stalled(e, lastAct)) begin
               eTo = 1; finished = 1;
            end
         end else if (e == addrE + 2) begin
            eMiso = 1; lastAct = e;
         end else begin
            if (sclkFall) begin
               rises++; lastAct = e;
               if (rises == W) begin eMiso = 0; finished = 1; end
            end else if (stalled(e, lastAct)) begin
               eTo = 1; eMiso = 0; finished = 1;
            end
         end
      end
   end

   // Compare process: reset low forces every output to 0 regardless of clk.
   always @(negedge clk) begin
      chk("m_ale",  addrLatchEnable,  rst_n & eAle);
      chk("m_dwe",  dmWriteEnable,    rst_n & eDwe);
      chk("m_spl",  srParallelLoad,   rst_n & eSpl);
      chk("m_miso", misoBufferEnable, rst_n & eMiso);
      chk("m_busy", busy,             rst_n & eBusy);
      chk("m_to",   timeoutErr,       rst_n & eTo);
   end

   // ---------------- stimulus ----------------
   task automatic tick(input logic cs, input logic r, input logic f);
      csConditioned = cs; sclkRise = r; sclkFall = f;
      @(negedge clk);
   endtask

   task automatic sclkBit();
      tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 1); tick(0, 0, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_miso", misoBufferEnable, 1'b0);
      chk("rst_ale",  addrLatchEnable, 1'b0);
      rst_n = 1'b1;
      tick(1, 0, 0); tick(1, 1, 0);
      chk("idle_cs_high", busy, 1'b0);

      // Write: address 0x54, data 0xA5
      shiftRegOut = 8'h54;
      tick(0, 0, 0);
      chk("wr_start_busy", busy, 1'b1);
      repeat (7) sclkBit();
      tick(0, 1, 0);
      chk("wr_ale", addrLatchEnable, 1'b1);
      tick(0, 0, 0);
      chk("wr_ale_drop", addrLatchEnable, 1'b0);
      chk("wr_no_spl", srParallelLoad, 1'b0);
      tick(0, 0, 1); tick(0, 0, 0);
      shiftRegOut = 8'hA5;
      repeat (7) sclkBit();
      tick(0, 1, 0);
      chk("wr_dwe", dmWriteEnable, 1'b1);
      tick(0, 0, 0);
      chk("wr_dwe_drop", dmWriteEnable, 1'b0);
      chk("wr_done_busy", busy, 1'b1);
      tick(1, 0, 0);
      chk("wr_end_idle", busy, 1'b0);

      // Read: address 0x55
      shiftRegOut = 8'h55;
      tick(0, 0, 0);
      repeat (7) sclkBit();
      tick(0, 1, 0);
      chk("rd_ale", addrLatchEnable, 1'b1);
      tick(0, 0, 0);
      chk("rd_spl", srParallelLoad, 1'b1);
      chk("rd_miso_pre", misoBufferEnable, 1'b0);
      tick(0, 0, 1);
      chk("rd_miso_on", misoBufferEnable, 1'b1);
      chk("rd_spl_drop", srParallelLoad, 1'b0);
      tick(0, 0, 0);
      repeat (7) sclkBit();
      tick(0, 1, 0); tick(0, 0, 0);
      chk("rd_miso_hold", misoBufferEnable, 1'b1);
      tick(0, 0, 1);
      chk("rd_miso_off", misoBufferEnable, 1'b0);
      chk("rd_done_busy", busy, 1'b1);
      tick(0, 1, 1);
      chk("rd_done_ignores", misoBufferEnable, 1'b0);
      tick(1, 0, 0);
      chk("rd_end_idle", busy, 1'b0);

      // Abort after 5 data rises of a write
      shiftRegOut = 8'h54;
      tick(0, 0, 0);
      repeat (8) sclkBit();
      repeat (5) sclkBit();
      tick(1, 0, 0);
      chk("ab_busy", busy, 1'b0);
      chk("ab_dwe", dmWriteEnable, 1'b0);
      repeat (3) tick(1, 1, 0);
      chk("ab_stay_idle", busy, 1'b0);

      // CS rises together with the 8th address rise
      tick(0, 0, 0);
      repeat (7) sclkBit();
      tick(1, 1, 0);
      chk("sim_no_ale", addrLatchEnable, 1'b0);
      chk("sim_idle", busy, 1'b0);
      tick(1, 0, 0);
      chk("sim_no_ale2", addrLatchEnable, 1'b0);

      // Asynchronous reset during READ_SHIFT
      shiftRegOut = 8'h55;
      tick(0, 0, 0);
      repeat (8) sclkBit();
      repeat (3) sclkBit();
      chk("rs_in_shift", misoBufferEnable, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_async_miso", misoBufferEnable, 1'b0);
      chk("rs_async_busy", busy, 1'b0);
      tick(0, 0, 0);
      rst_n = 1'b1;
      tick(1, 0, 0);
      chk("rs_after_idle", busy, 1'b0);
      tick(0, 0, 0);
      chk("rs_restart", busy, 1'b1);
      tick(1, 0, 0);

      // Watchdog: 3 rises then 16 idle cycles
      tick(0, 0, 0);
      repeat (3) tick(0, 1, 0);
      for (int i = 1; i <= 16; i++) begin
         tick(0, 0, 0);
         if (i == 15) chk("to_early", timeoutErr, 1'b0);
      end
      chk("to_pulse", timeoutErr, TO_EN);
      tick(0, 1, 0);
      chk("to_one_cycle", timeoutErr, 1'b0);
      chk("to_busy", busy, 1'b1);
      tick(1, 0, 0);
      chk("to_end_idle", busy, 1'b0);

      tick(1, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
